// File: rtl/f4_ram_ctrl_pkg.sv
// Shared definitions for the f4 RAM controller.
// This package holds the controller state set and the default geometry.
package f4_ram_ctrl_pkg;

    localparam int DEF_MAP_SIZE = 25;
    localparam int DEF_ADDR_W   = 7;
    localparam int REPLAY_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/f4_ram_ctrl.sv
// f4 RAM sequencer: one frame is written from S4, then read back by the consumer.
// Optional replay of the read pass is enabled with the macro F4_RAM_CTRL_REPLAY_EN.
module f4_ram_ctrl
    import f4_ram_ctrl_pkg::*;
#(
    parameter int MAP_SIZE = DEF_MAP_SIZE,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s4_vld,
    input  logic              fc_rd_en,
`ifdef F4_RAM_CTRL_REPLAY_EN
    input  logic [REPLAY_W-1:0] replay_cnt,
`endif
    output logic              f4_wr_en,
    output logic [ADDR_W-1:0] f4_waddr,
    output logic [ADDR_W-1:0] f4_raddr,
    output logic              f4_rd_vld,
    output logic              f4_rd_last,
    output logic              busy,
    output logic              frame_done,
    output logic              err_ovf
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_SIZE - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] rcnt_q, rcnt_d;
    logic              rd_vld_q, rd_last_q, frame_done_q, err_q;
    logic              fillAcc, issue, lastPass, wrapRead, finalIssue;

    assign fillAcc    = (state_q == ST_FILL) && s4_vld;
    assign issue      = (state_q == ST_DRAIN) && fc_rd_en;
    assign wrapRead   = issue && (rcnt_q == LAST_ADDR);
    assign wcnt_d     = (wcnt_q == LAST_ADDR) ? '0 : wcnt_q + 1'b1;
    assign rcnt_d     = (rcnt_q == LAST_ADDR) ? '0 : rcnt_q + 1'b1;
    assign finalIssue = wrapRead && lastPass;

`ifdef F4_RAM_CTRL_REPLAY_EN
    logic [REPLAY_W-1:0] replay_q, pass_q;

    // replay_cnt is captured at start so the pass count is fixed for the whole frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            replay_q <= '0;
            pass_q   <= '0;
        end else if (state_q == ST_IDLE && start) begin
            replay_q <= replay_cnt;
            pass_q   <= '0;
        end else if (wrapRead && !lastPass) begin
            pass_q   <= pass_q + 1'b1;
        end
    end

    assign lastPass = (pass_q == replay_q);
`else
    assign lastPass = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rd_vld_q     <= issue;
            rd_last_q    <= wrapRead;
            frame_done_q <= finalIssue;
            if (s4_vld && state_q != ST_FILL) begin
                err_q <= 1'b1;
            end
            if (fillAcc) begin
                wcnt_q <= wcnt_d;
            end
            if (issue) begin
                rcnt_q <= rcnt_d;
            end
            // FLUSH exists so frame_done lines up with the last read data
            case (state_q)
                ST_IDLE:  if (start) state_q <= ST_FILL;
                ST_FILL:  if (fillAcc && wcnt_q == LAST_ADDR) state_q <= ST_DRAIN;
                ST_DRAIN: if (finalIssue) state_q <= ST_FLUSH;
                ST_FLUSH: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign f4_wr_en   = fillAcc;
    assign f4_waddr   = wcnt_q;
    assign f4_raddr   = rcnt_q;
    assign f4_rd_vld  = rd_vld_q;
    assign f4_rd_last = rd_last_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);
    assign err_ovf    = err_q;

endmodule
